// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one registered 8-bit ALU among NREQ requesters.
// Requests are granted round-robin, one operation at a time is sequenced
// through the ALU, and the 16-bit result returns on a common valid/ready
// response channel tagged with the owning requester index.
// Optional build macro: ALU_DIV_ZERO_CHECK_EN -- divide/modulo by zero is
// answered directly with 16'hFFFF and rsp_err=1 instead of reaching the ALU.
module alu_rr_scheduler #(
  parameter  int NREQ    = 4,
  parameter  int ALU_LAT = 1,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ*4-1:0] req_oper,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_oper,
  input  logic [7:0]        alu_msb,
  input  logic [7:0]        alu_lsb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  // Wait counter must hold ALU_LAT (up to 8).
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  op_id;
  logic [CW-1:0]   wait_cnt;

  // Unpacked views of the per-requester payload buses.
  logic [7:0]      a_arr    [NREQ];
  logic [7:0]      b_arr    [NREQ];
  logic [3:0]      oper_arr [NREQ];

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [3:0]      sel_oper;
  logic            div_zero;

  logic            grant_fire;
  logic            dz_fire;
  logic            wait_done;
  logic            rsp_fire;

  // Split the packed request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]    = req_a[8*i +: 8];
      b_arr[i]    = req_b[8*i +: 8];
      oper_arr[i] = req_oper[4*i +: 4];
    end
  end

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign sel_a    = a_arr[grant_idx];
  assign sel_b    = b_arr[grant_idx];
  assign sel_oper = oper_arr[grant_idx];

`ifdef ALU_DIV_ZERO_CHECK_EN
  // Opcodes 0x3 (divide) and 0x4 (modulo) with a zero divisor never reach the ALU.
  assign div_zero = ((sel_oper == 4'h3) || (sel_oper == 4'h4)) && (sel_b == 8'h00);
`else
  assign div_zero = 1'b0;
`endif

  // Next-state decode and single-cycle strobes for the datapath registers.
  always_comb begin
    state_n    = state;
    grant_fire = 1'b0;
    dz_fire    = 1'b0;
    wait_done  = 1'b0;
    rsp_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_found) begin
          grant_fire = 1'b1;
          if (div_zero) begin
            dz_fire = 1'b1;
            state_n = RESP;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (wait_cnt == CW'(1)) begin
          wait_done = 1'b1;
          state_n   = RESP;
        end
      end
      RESP: begin
        // No grant in the handshake cycle: the next search happens in IDLE.
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Grant is combinational and only ever offered while idle, so at most one bit is set.
  always_comb begin
    req_ready = '0;
    if (grant_fire) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Arbitration pointer, ALU latency counter and response valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(NREQ - 1);
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (grant_fire) begin
        last_grant <= grant_idx;
      end
      if (state == ISSUE) begin
        wait_cnt <= CW'(ALU_LAT);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      if (wait_done || dz_fire) begin
        rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Owner of the in-flight op; only meaningful between grant and response.
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      op_id <= grant_idx;
    end
  end

  // ALU operand registers: loaded only when an op is actually issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_oper <= '0;
    end else if (grant_fire && !div_zero) begin
      alu_a    <= sel_a;
      alu_b    <= sel_b;
      alu_oper <= sel_oper;
    end
  end

  // Response payload: ALU result at the end of WAIT, or the fixed error word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (wait_done) begin
      rsp_data <= {alu_msb, alu_lsb};
      rsp_id   <= op_id;
    end else if (dz_fire) begin
      rsp_data <= 16'hFFFF;
      rsp_id   <= grant_idx;
    end
  end

`ifdef ALU_DIV_ZERO_CHECK_EN
  // Error flag rises with a short-circuited response and drops on its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (dz_fire) begin
      rsp_err <= 1'b1;
    end else if (wait_done || rsp_fire) begin
      rsp_err <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
